// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the nonce-search engine.
// States, command codes, register addresses and status bit positions.
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISPATCH  = 3'd1,
    ST_WAIT      = 3'd2,
    ST_CHECK     = 3'd3,
    ST_FOUND     = 3'd4,
    ST_EXHAUSTED = 3'd5
  } state_t;

  localparam logic [31:0] CMD_START = 32'hffffffff;
  localparam logic [31:0] CMD_ACK   = 32'h0f0f0f0f;
  localparam logic [31:0] CMD_ABORT = 32'hff0000ff;

  localparam logic [4:0] ADDR_CMD    = 5'd16;
  localparam logic [4:0] ADDR_NSTART = 5'd17;
  localparam logic [4:0] ADDR_NEND   = 5'd18;
  localparam logic [4:0] ADDR_TGT0   = 5'd19;
  localparam logic [4:0] ADDR_TGT7   = 5'd26;

  localparam logic [4:0] ADDR_STATUS = 5'd16;
  localparam logic [4:0] ADDR_WNONCE = 5'd17;
  localparam logic [4:0] ADDR_BASE   = 5'd18;
  localparam logic [4:0] ADDR_HCNT   = 5'd19;

  localparam int ST_BUSY_BIT  = 4;
  localparam int ST_EXH_BIT   = 3;
  localparam int ST_FOUND_BIT = 2;

endpackage

// File: rtl/acc_lane.sv
// acc_lane: one hash lane with nonce insertion, sticky done and latch.
// hit compares the latched hash against target as unsigned 256-bit.
module acc_lane #(
  parameter int NONCE_WORD = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         clear,
  input  logic [511:0] blk,
  input  logic [31:0]  nonce,
  input  logic [255:0] target,
  output logic         done_flag,
  output logic [255:0] hash,
  output logic         hit
);

  logic [511:0] msg;
  logic         core_done;
  logic [255:0] core_hash;

  // splice this lane's nonce into the block
  always_comb begin
    msg = blk;
    msg[32*NONCE_WORD +: 32] = nonce;
  end

  sha256_module u_core (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .block (msg),
    .done  (core_done),
    .hash  (core_hash)
  );

  // sticky completion flag and result latch
  always_ff @(posedge clk) begin
    if (reset) begin
      done_flag <= 1'b0;
      hash      <= '0;
    end else if (clear) begin
      done_flag <= 1'b0;
    end else if (core_done) begin
      done_flag <= 1'b1;
      hash      <= core_hash;
    end
  end

  assign hit = hash < target;

endmodule

// File: rtl/sha256_module.sv
// sha256_module: iterative single-block SHA-256, one round per cycle.
// Word i of the message is block[32i+:32]; hash is {H0..H7}, H0 in MSBs.
module sha256_module (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block,
  output logic         done,
  output logic [255:0] hash
);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] HI = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [6:0]  rnd;
  logic        busy;
  logic [31:0] t1, t2, wn;

  // round function and message schedule for the current round
  always_comb begin
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
       + ((e & f) ^ (~e & g)) + K[rnd[5:0]] + w[0];
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
       + ((a & b) ^ (a & c) ^ (b & c));
    wn = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10))
       + w[9]
       + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3))
       + w[0];
  end

  // load on start, run 64 rounds, then fold into the digest
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      rnd  <= '0;
      hash <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        rnd  <= '0;
        {a, b, c, d, e, f, g, h} <= HI;
        for (int i = 0; i < 16; i++)
          w[i] <= block[32*i +: 32];
      end else if (busy) begin
        if (rnd == 7'd64) begin
          busy <= 1'b0;
          done <= 1'b1;
          hash <= {HI[255:224] + a, HI[223:192] + b,
                   HI[191:160] + c, HI[159:128] + d,
                   HI[127:96]  + e, HI[95:64]   + f,
                   HI[63:32]   + g, HI[31:0]    + h};
        end else begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= wn;
          rnd <= rnd + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/acc_nonce_search.sv
// acc_nonce_search: Avalon-MM nonce search over N_CORES SHA-256 lanes.
// Sweeps a nonce range, stops on first hash below target or exhaustion.
module acc_nonce_search
  import acc_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int NONCE_WORD = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [4:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] data_out,
  output logic        irq
);

  logic [511:0] blk;
  logic [255:0] target;
  logic [31:0]  nonce_start, nonce_end;
  logic [31:0]  cmd_in, cmd;
  state_t       state;
  logic [2:0]   st_raw;
  logic [31:0]  base, hash_cnt, win_nonce;
  logic [255:0] win_hash;

  logic [N_CORES-1:0] valid, lane_ok, lane_start;
  logic [N_CORES-1:0] lane_done, lane_hit;
  logic [255:0]       lane_hash [N_CORES];

  logic         wr_en, abort, lane_rst, dispatch;
  logic         all_done, any_hit;
  logic [31:0]  sel_off;
  logic [255:0] sel_hash;
  logic [2:0]   toff;
  logic [31:0]  status, rdata;

  assign wr_en    = chipselect && write;
  assign abort    = cmd == CMD_ABORT;
  assign lane_rst = reset || abort;
  assign dispatch = state == ST_DISPATCH;
  assign toff     = 3'(address - ADDR_TGT0);
  assign st_raw   = state;
  assign all_done = &(lane_done | ~valid);

  // a lane is live while its nonce stays within range, no 32-bit wrap
  always_comb begin
    lane_ok = '0;
    for (int i = 0; i < N_CORES; i++)
      lane_ok[i] = ({1'b0, base} + 33'(i)) <= {1'b0, nonce_end};
  end

  assign lane_start = dispatch ? lane_ok : '0;

  for (genvar i = 0; i < N_CORES; i++) begin : g_lane
    acc_lane #(.NONCE_WORD(NONCE_WORD)) u_lane (
      .clk       (clk),
      .reset     (lane_rst),
      .start     (lane_start[i]),
      .clear     (dispatch),
      .blk       (blk),
      .nonce     (base + 32'(i)),
      .target    (target),
      .done_flag (lane_done[i]),
      .hash      (lane_hash[i]),
      .hit       (lane_hit[i])
    );
  end

  // lowest-index valid hit wins
  always_comb begin
    any_hit  = 1'b0;
    sel_off  = '0;
    sel_hash = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (valid[i] && lane_hit[i]) begin
        any_hit  = 1'b1;
        sel_off  = 32'(i);
        sel_hash = lane_hash[i];
      end
    end
  end

  // register file writes; config frozen unless idle, command self-clears
  always_ff @(posedge clk) begin
    if (reset) begin
      blk         <= '0;
      target      <= '0;
      nonce_start <= '0;
      nonce_end   <= '0;
      cmd_in      <= '0;
      cmd         <= '0;
    end else begin
      cmd    <= cmd_in;
      cmd_in <= '0;
      if (wr_en) begin
        if (address == ADDR_CMD)
          cmd_in <= writedata;
        else if (state == ST_IDLE) begin
          if (!address[4])
            blk[{address[3:0], 5'd0} +: 32] <= writedata;
          else if (address == ADDR_NSTART)
            nonce_start <= writedata;
          else if (address == ADDR_NEND)
            nonce_end <= writedata;
          else if (address >= ADDR_TGT0 && address <= ADDR_TGT7)
            target[{toff, 5'd0} +: 32] <= writedata;
        end
      end
    end
  end

  // search sequencer with registered irq
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      base      <= '0;
      hash_cnt  <= '0;
      win_nonce <= '0;
      win_hash  <= '0;
      valid     <= '0;
      irq       <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      valid <= '0;
      irq   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd == CMD_START) begin
            hash_cnt <= '0;
            if (nonce_start > nonce_end) begin
              state <= ST_EXHAUSTED;
              irq   <= 1'b1;
            end else begin
              base  <= nonce_start;
              state <= ST_DISPATCH;
            end
          end
        end
        ST_DISPATCH: begin
          valid <= lane_ok;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (all_done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          hash_cnt <= hash_cnt + 32'($countones(valid));
          if (any_hit) begin
            win_nonce <= base + sel_off;
            win_hash  <= sel_hash;
            state     <= ST_FOUND;
            irq       <= 1'b1;
          end else if (({1'b0, base} + 33'(N_CORES))
                       > {1'b0, nonce_end}) begin
            state <= ST_EXHAUSTED;
            irq   <= 1'b1;
          end else begin
            base  <= base + 32'(N_CORES);
            state <= ST_DISPATCH;
          end
        end
        ST_FOUND, ST_EXHAUSTED: begin
          if (cmd == CMD_ACK) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // status word and read mux
  always_comb begin
    status = '0;
    status[ST_BUSY_BIT]  = dispatch || state == ST_WAIT
                        || state == ST_CHECK;
    status[ST_EXH_BIT]   = state == ST_EXHAUSTED;
    status[ST_FOUND_BIT] = state == ST_FOUND;
    status[1:0]          = st_raw[1:0];
    rdata = '0;
    unique case (1'b1)
      (address < 5'd8):
        rdata = (state == ST_FOUND)
              ? win_hash[{~address[2:0], 5'd0} +: 32] : '0;
      (address == ADDR_STATUS): rdata = status;
      (address == ADDR_WNONCE): rdata = win_nonce;
      (address == ADDR_BASE):   rdata = base;
      (address == ADDR_HCNT):   rdata = hash_cnt;
      default:                  rdata = '0;
    endcase
  end

  // registered read data
  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else       data_out <= rdata;
  end

endmodule
